// File: rtl/circular_buffer_pkg.sv
// Shared types for the reorder circular buffer and its verdict table:
// status encodings, per-entry state and the wrapping pointer increment.
package circular_buffer_pkg;

  typedef enum logic [1:0] {
    STATUS_PENDING  = 2'b00,
    STATUS_REJECTED = 2'b01,
    STATUS_ACCEPTED = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    ENTRY_FREE,
    ENTRY_PENDING,
    ENTRY_REJECTED,
    ENTRY_ACCEPTED
  } entry_state_e;

  typedef struct packed {
    logic    in_use;
    status_e status;
  } entry_t;

  localparam entry_t ENTRY_RESET = '{in_use: 1'b0, status: STATUS_PENDING};

  function automatic entry_state_e entry_state(input entry_t e);
    entry_state_e s;
    if (!e.in_use) begin
      s = ENTRY_FREE;
    end else begin
      case (e.status)
        STATUS_ACCEPTED: s = ENTRY_ACCEPTED;
        STATUS_REJECTED: s = ENTRY_REJECTED;
        default:         s = ENTRY_PENDING;
      endcase
    end
    return s;
  endfunction

  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned size);
    return (ptr >= size - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/verdict_table_if.sv
// Front-end / filter / circular-buffer side bundle of the verdict table.
// master drives requests, verdicts, queries and releases; slave is the table.
interface verdict_table_if #(
  parameter int unsigned TAG_WIDTH            = 6,
  parameter int unsigned CIRCULAR_BUFFER_SIZE = 50
);
  localparam int unsigned CNT_W = $clog2(CIRCULAR_BUFFER_SIZE + 1);

  logic                 alloc_req;
  logic                 alloc_ok;
  logic [TAG_WIDTH-1:0] alloc_tag;
  logic                 verdict_valid;
  logic [TAG_WIDTH-1:0] verdict_tag;
  logic                 verdict_accept;
  logic [TAG_WIDTH-1:0] reorder_tag_out;
  logic [1:0]           packet_status;
  logic                 release_valid;
  logic [TAG_WIDTH-1:0] release_tag;
  logic [CNT_W-1:0]     free_count;
  logic                 err;

  modport master (
    output alloc_req, verdict_valid, verdict_tag, verdict_accept,
           reorder_tag_out, release_valid, release_tag,
    input  alloc_ok, alloc_tag, packet_status, free_count, err
  );

  modport slave (
    input  alloc_req, verdict_valid, verdict_tag, verdict_accept,
           reorder_tag_out, release_valid, release_tag,
    output alloc_ok, alloc_tag, packet_status, free_count, err
  );
endinterface

// File: rtl/verdict_table_tag_ring_ptr.sv
// Wrapping tag pointer: counts 0..SIZE-1 and wraps, advancing on inc_i.
module tag_ring_ptr
  import circular_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned SIZE  = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] ptr_o
);
  logic [WIDTH-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = WIDTH'(wrap_inc(32'(ptr_q), SIZE));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;
endmodule

// File: rtl/verdict_table.sv
// Reorder tag allocator and verdict store read by the circular buffer.
// Define VERDICT_TABLE_ERR_EN to enable protocol checking and the sticky err flag.
module verdict_table
  import circular_buffer_pkg::*;
#(
  parameter int unsigned TAG_WIDTH            = 6,
  parameter int unsigned CIRCULAR_BUFFER_SIZE = 50
) (
  input logic            clk,
  input logic            rst,
  verdict_table_if.slave bus
);
  localparam int unsigned SIZE  = CIRCULAR_BUFFER_SIZE;
  localparam int unsigned CNT_W = $clog2(SIZE + 1);
  localparam int unsigned IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  entry_t               table_q [SIZE];
  entry_t               table_d [SIZE];
  logic [CNT_W-1:0]     free_count_q, free_count_d;
  logic [TAG_WIDTH-1:0] alloc_ptr, rel_ptr;

  logic             v_in_range, r_in_range, q_in_range;
  logic [IDX_W-1:0] a_idx, v_idx, r_idx, q_idx;
  logic             alloc_fire, verdict_apply, release_apply, release_frees;

  // Out-of-range tags are steered to entry 0 and masked by the in-range flags.
  assign v_in_range = 32'(bus.verdict_tag) < SIZE;
  assign r_in_range = 32'(bus.release_tag) < SIZE;
  assign q_in_range = 32'(bus.reorder_tag_out) < SIZE;
  assign a_idx      = IDX_W'(alloc_ptr);
  assign v_idx      = v_in_range ? IDX_W'(bus.verdict_tag) : '0;
  assign r_idx      = r_in_range ? IDX_W'(bus.release_tag) : '0;
  assign q_idx      = q_in_range ? IDX_W'(bus.reorder_tag_out) : '0;

  assign bus.alloc_ok   = !table_q[a_idx].in_use;
  assign bus.alloc_tag  = alloc_ptr;
  assign bus.free_count = free_count_q;
  assign alloc_fire     = bus.alloc_req && bus.alloc_ok;

  assign bus.packet_status = (q_in_range && table_q[q_idx].in_use) ? table_q[q_idx].status
                                                                   : STATUS_PENDING;

`ifdef VERDICT_TABLE_ERR_EN
  entry_state_e verdict_state, release_state;
  logic         err_q;

  // Legality is judged on the pre-edge table, so a same-cycle verdict cannot
  // make a release legal and a same-cycle grant cannot make a verdict legal.
  assign verdict_state = entry_state(table_q[v_idx]);
  assign release_state = entry_state(table_q[r_idx]);
  assign verdict_apply = bus.verdict_valid && v_in_range && (verdict_state == ENTRY_PENDING);
  assign release_apply = bus.release_valid && r_in_range && (bus.release_tag == rel_ptr)
                      && ((release_state == ENTRY_ACCEPTED) || (release_state == ENTRY_REJECTED));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_q | (bus.verdict_valid && !verdict_apply)
                             | (bus.release_valid && !release_apply);
  end

  assign bus.err = err_q;
`else
  logic rel_ptr_unused;

  assign verdict_apply  = bus.verdict_valid && v_in_range;
  assign release_apply  = bus.release_valid && r_in_range;
  assign rel_ptr_unused = ^rel_ptr;
  assign bus.err        = 1'b0;
`endif

  // Only a release of an occupied entry returns a slot to the free pool.
  assign release_frees = release_apply && table_q[r_idx].in_use;

  always_comb begin
    table_d = table_q;
    if (release_apply) table_d[r_idx] = ENTRY_RESET;
    if (alloc_fire)    table_d[a_idx] = '{in_use: 1'b1, status: STATUS_PENDING};
    if (verdict_apply) table_d[v_idx].status = bus.verdict_accept ? STATUS_ACCEPTED
                                                                  : STATUS_REJECTED;
  end

  always_comb begin
    free_count_d = free_count_q;
    case ({release_frees, alloc_fire})
      2'b10:   free_count_d = free_count_q + CNT_W'(1);
      2'b01:   free_count_d = free_count_q - CNT_W'(1);
      default: free_count_d = free_count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SIZE; i++) table_q[i] <= ENTRY_RESET;
      free_count_q <= CNT_W'(SIZE);
    end else begin
      table_q      <= table_d;
      free_count_q <= free_count_d;
    end
  end

  tag_ring_ptr #(.WIDTH(TAG_WIDTH), .SIZE(SIZE)) u_alloc_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (alloc_fire),
    .ptr_o (alloc_ptr)
  );

  tag_ring_ptr #(.WIDTH(TAG_WIDTH), .SIZE(SIZE)) u_rel_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (release_apply),
    .ptr_o (rel_ptr)
  );
endmodule
